mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the fetch/LSU memory bus arbiter: FSM states,
// default starvation limit and the memory command payload.
package mem_bus_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_LSU = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Instruction fetch is always a full-word read.
    function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
        mem_cmd_t c;
        c.we    = 1'b0;
        c.be    = 4'hF;
        c.addr  = addr;
        c.wdata = 32'h0;
        return c;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch, LSU) arbiter onto a single-outstanding memory port.
// LSU has priority; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    arb_state_t  state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        mem_req_q, mem_req_d;
    logic        if_gnt_q, if_gnt_d;
    logic        lsu_gnt_q, lsu_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        lsu_rvalid_q, lsu_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;

    logic fetch_forced;
    logic lsu_wins;

    assign fetch_forced = if_req && (starve_q == LIMIT);
    assign lsu_wins     = lsu_req && !fetch_forced;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        cmd_d        = cmd_q;
        mem_req_d    = mem_req_q;
        if_gnt_d     = 1'b0;
        lsu_gnt_d    = 1'b0;
        if_rvalid_d  = 1'b0;
        lsu_rvalid_d = 1'b0;
        if_rdata_d   = if_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                // mem_ack here is either stray or stale after reset: ignored.
                if (lsu_wins) begin
                    state_d   = ARB_BUSY_LSU;
                    cmd_d     = '{we: lsu_we, be: lsu_be, addr: lsu_addr, wdata: lsu_wdata};
                    mem_req_d = 1'b1;
                    lsu_gnt_d = 1'b1;
                    if (if_req && starve_q != LIMIT)
                        starve_d = starve_q + 3'd1;
                end else if (if_req) begin
                    state_d   = ARB_BUSY_IF;
                    cmd_d     = fetch_cmd(if_addr);
                    mem_req_d = 1'b1;
                    if_gnt_d  = 1'b1;
                    starve_d  = 3'd0;
                end
            end
            ARB_BUSY_IF: begin
                if (mem_ack) begin
                    state_d     = ARB_IDLE;
                    mem_req_d   = 1'b0;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                end
            end
            ARB_BUSY_LSU: begin
                if (mem_ack) begin
                    state_d      = ARB_IDLE;
                    mem_req_d    = 1'b0;
                    lsu_rvalid_d = 1'b1;
                    // Writes leave the last read value visible.
                    if (!cmd_q.we)
                        lsu_rdata_d = mem_rdata;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            starve_q     <= 3'd0;
            cmd_q        <= '0;
            mem_req_q    <= 1'b0;
            if_gnt_q     <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            if_rdata_q   <= 32'h0;
            lsu_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            cmd_q        <= cmd_d;
            mem_req_q    <= mem_req_d;
            if_gnt_q     <= if_gnt_d;
            lsu_gnt_q    <= lsu_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign if_gnt     = if_gnt_q;
    assign lsu_gnt    = lsu_gnt_q;
    assign if_rvalid  = if_rvalid_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign lsu_rdata  = lsu_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = cmd_q.we;
    assign mem_be     = cmd_q.be;
    assign mem_addr   = cmd_q.addr;
    assign mem_wdata  = cmd_q.wdata;

endmodule
